// File: rtl/mk_key_store.sv
// ---------------------------------------------------------------------------
// mk_key_store
//
// Master-key storage stage that sits directly behind the MK control unit.
// It holds a WORDS x DW master key, streams it back on request, keeps the
// session-owner register and wipes the key word by word on a zeroize request.
//
// Build option:
//   MK_RD_LOCK_EN - when defined, read beats carry key data only while the
//                   active session owner matches the requesting l3_id; the
//                   stream still delivers WORDS beats, just zeroed.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   clr_mk                  zeroize request (pulse or level)
//   wr_open                 opens the write window (from IDLE)
//   wr_en/wr_addr/wr_data   L3 write-data beats
//   rd_open                 starts a read stream (from IDLE)
//   rd_rdy                  downstream ready for a read beat
//   rd_vld/rd_data/rd_last  read beat stream
//   l3_id                   requester id
//   ss_set/ss_clr           session set / clear strobes
//   ssid/ssid_vld           session owner id / session active
//   key_vld                 complete key stored
//   key_out                 key to crypto engine, zero unless key_vld
//   zbusy                   zeroization in progress
// ---------------------------------------------------------------------------
module mk_key_store #(
    parameter int WORDS = 8,
    parameter int DW    = 32,
    parameter int AW    = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_mk,
    input  logic                wr_open,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic                rd_open,
    input  logic                rd_rdy,
    output logic                rd_vld,
    output logic [DW-1:0]       rd_data,
    output logic                rd_last,
    input  logic [2:0]          l3_id,
    input  logic                ss_set,
    input  logic                ss_clr,
    output logic [2:0]          ssid,
    output logic                ssid_vld,
    output logic                key_vld,
    output logic [WORDS*DW-1:0] key_out,
    output logic                zbusy
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    // One-hot state encoding
    localparam logic [3:0] S_IDLE = 4'b0001;
    localparam logic [3:0] S_WR   = 4'b0010;
    localparam logic [3:0] S_RD   = 4'b0100;
    localparam logic [3:0] S_ZERO = 4'b1000;

    localparam logic [IW-1:0] LAST_IDX  = IW'(WORDS - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);
    localparam logic [AW-1:0] NUM_ADDR  = AW'(WORDS);

    logic [3:0]       state;
    logic [DW-1:0]    key_mem [WORDS];
    logic [WORDS-1:0] mask;
    logic [WORDS-1:0] mask_next;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    zcnt;
    logic [IW-1:0]    wr_idx;
    logic             wr_hit;
    logic             rd_allow;

    // Write beats only land inside the window and only for in-range
    // addresses. mask_next includes the current beat so the closing beat
    // can decide key_vld in the same edge it is written.
    always_comb begin
        wr_idx    = wr_addr[IW-1:0];
        wr_hit    = (state == S_WR) && wr_en && (wr_addr < NUM_ADDR);
        mask_next = mask | (WORDS'(1) << wr_idx);
    end

    // Main FSM plus key array. clr_mk overrides every state so a zeroize
    // request cannot be lost mid-write or mid-read; re-asserting it during
    // ZERO restarts the wipe from word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            mask    <= '0;
            idx     <= '0;
            zcnt    <= '0;
            key_vld <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                key_mem[i] <= '0;
            end
        end else if (clr_mk) begin
            state   <= S_ZERO;
            zcnt    <= '0;
            idx     <= '0;
            mask    <= '0;
            key_vld <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_open) begin
                        state   <= S_WR;
                        mask    <= '0;
                        key_vld <= 1'b0;
                    end else if (rd_open) begin
                        state <= S_RD;
                        idx   <= '0;
                    end
                end
                S_WR: begin
                    if (wr_hit) begin
                        key_mem[wr_idx] <= wr_data;
                        mask            <= mask_next;
                        if (wr_addr == LAST_ADDR) begin
                            state   <= S_IDLE;
                            key_vld <= &mask_next;
                        end
                    end
                end
                S_RD: begin
                    if (rd_rdy) begin
                        if (idx == LAST_IDX) begin
                            state <= S_IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_ZERO: begin
                    key_mem[zcnt] <= '0;
                    if (zcnt == LAST_IDX) begin
                        state <= S_IDLE;
                        zcnt  <= '0;
                    end else begin
                        zcnt <= zcnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Session owner register. It runs independently of the FSM; only
    // clr_mk reaches across, and any clear beats a simultaneous set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssid     <= '0;
            ssid_vld <= 1'b0;
        end else if (clr_mk || ss_clr) begin
            ssid     <= '0;
            ssid_vld <= 1'b0;
        end else if (ss_set) begin
            ssid     <= l3_id;
            ssid_vld <= 1'b1;
        end
    end

    // Read-lock qualifier: with the lock built in, key words only leave on
    // the read path for the current session owner.
`ifdef MK_RD_LOCK_EN
    always_comb begin
        rd_allow = ssid_vld && (ssid == l3_id);
    end
`else
    always_comb begin
        rd_allow = 1'b1;
    end
`endif

    // Read stream outputs come straight from state and idx, so data is
    // naturally stable while the consumer stalls.
    always_comb begin
        rd_vld  = (state == S_RD);
        rd_last = rd_vld && (idx == LAST_IDX);
        rd_data = '0;
        if (rd_vld && key_vld && rd_allow) begin
            rd_data = key_mem[idx];
        end
        zbusy = (state == S_ZERO);
    end

    // Key to the crypto engine is masked off whenever the key is incomplete
    // or being wiped.
    always_comb begin
        key_out = '0;
        for (int i = 0; i < WORDS; i++) begin
            key_out[i*DW +: DW] = key_mem[i] & {DW{key_vld}};
        end
    end

endmodule

// File: doc/mk_key_store.md
Name: mk_key_store

Overview:
- Master-key storage stage directly downstream of the MK control unit.
- Consumes the unit's wr_open, rd_open, ss_set and ss_clr strobes, plus the L3 write-data stream.
- Holds a 256-bit master key as 8 x 32-bit words, streams it back on read, and keeps the session-owner register; ssid/ssid_vld are fed back to the control unit.
- Performs multi-cycle zeroization on clr_mk.

Parameters:
- WORDS, 8, number of 32-bit key words; WORDS-1 is the closing write address.
- DW, 32, key word width.
- AW, 14, write address width; must match the L3 write address bus.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- clr_mk  input  1  zeroize request; single-cycle pulse or level
- wr_open  input  1  one-cycle strobe; opens the write window
- wr_en  input  1  write-data beat valid
- wr_addr  input  AW  word index of the beat
- wr_data  input  DW  write-data beat
- rd_open  input  1  one-cycle strobe; starts the read stream
- rd_rdy  input  1  downstream ready for a read beat
- rd_vld  output  1  read beat valid
- rd_data  output  DW  read beat
- rd_last  output  1  marks the final read beat
- l3_id  input  3  requester id
- ss_set  input  1  session set strobe
- ss_clr  input  1  session clear strobe
- ssid  output  3  session owner id
- ssid_vld  output  1  session active
- key_vld  output  1  complete key stored
- key_out  output  WORDS*DW  key to the crypto engine; all-zero when key_vld=0
- zbusy  output  1  zeroization in progress

Behaviour:
- Reset: all outputs 0; key array 0; write mask 0; FSM in IDLE.
- FSM states: IDLE, WR_WIN, RD_STRM, ZERO. FSM is one-hot.
- IDLE transitions: wr_open -> WR_WIN, clear write mask, clear key_vld. rd_open -> RD_STRM, idx=0. Both strobes in the same cycle: wr_open wins.
- WR_WIN:
  - wr_en with wr_addr<WORDS: writes key[wr_addr] at the clock edge and sets mask[wr_addr].
  - wr_en with wr_addr>=WORDS: ignored.
  - wr_en with wr_addr==WORDS-1: closes the window -> IDLE. key_vld=1 on the next cycle only if the mask, including this beat, is all ones; otherwise key_vld stays 0.
  - Rewrite of a word already written: allowed, last write wins.
- wr_en outside WR_WIN: ignored.
- RD_STRM:
  - rd_vld=1 combinationally from state.
  - rd_data = key[idx] when key_vld=1, else 0.
  - rd_last = (idx==WORDS-1).
  - Handshake is rd_vld & rd_rdy: idx increments; the handshake on the last beat -> IDLE.
  - rd_vld is held while rd_rdy=0; rd_data is stable while stalled.
- ZERO:
  - Entered from any state on clr_mk, including mid-write and mid-read.
  - key_vld clears and rd_vld drops on the following cycle.
  - Clears one word per cycle, counter 0..WORDS-1; zbusy=1 for exactly WORDS cycles, then -> IDLE.
  - clr_mk asserted during ZERO restarts the counter at 0.
  - wr_open, rd_open and wr_en are ignored while in ZERO.
- Session register:
  - ss_set: ssid_vld<=1, ssid<=l3_id.
  - ss_clr: ssid_vld<=0, ssid<=0.
  - ss_set and ss_clr in the same cycle: clear wins.
  - clr_mk clears the session in the same cycle it starts zeroization.
  - The session register is independent of the FSM state, apart from clr_mk.
- Latency: key_vld, ssid and ssid_vld are registered, visible 1 cycle after the causing edge.
- key_out is combinational from the key array, AND-gated with key_vld.

Optional Feature:
- MK_RD_LOCK_EN defined: in RD_STRM, rd_data is forced to 0 unless ssid_vld=1 and ssid==l3_id. The stream length and handshake are unchanged, so the consumer still sees WORDS beats.
- MK_RD_LOCK_EN undefined: rd_data depends only on key_vld.

Test Plan:
- Reset, wr_open, beats addr 0..7 with data 32'h1111_0000+addr:
  - key_vld=1 one cycle after the addr-7 beat.
  - key_out[31:0]=32'h1111_0000 and key_out[255:224]=32'h1111_0007.
- Same as above but skip addr 3:
  - key_vld stays 0 after the addr-7 beat; key_out=0.
- With a valid key, rd_open and rd_rdy toggling 1,0,1,... :
  - Exactly 8 beats, in order 32'h1111_0000..32'h1111_0007.
  - rd_last only on the 8th beat; rd_data stable during stalls.
- clr_mk pulsed at read beat 3:
  - rd_vld=0 next cycle; zbusy=1 for 8 cycles; key_vld=0.
  - A following rd_open streams 8 zero beats.
- Session sequence:
  - l3_id=5 with ss_set -> ssid=5, ssid_vld=1.
  - ss_set and ss_clr asserted together -> ssid_vld=0, ssid=0.
- With MK_RD_LOCK_EN, ssid=2, l3_id=4:
  - Read returns 8 zero beats.
  - Changing l3_id to 2 and re-reading returns the real key words.
